quadrature_input_conditioner: RTL and testbench

- Front-end stage for raw encoder channels A/B from the motor (simulated or physical).
- Synchronises and glitch-filters both channels, then decodes 4x quadrature.
- Produces a one-cycle step strobe, direction, a signed position count and illegal-transition error tracking.
- Filtered A/B and the step strobe feed the downstream velocity and step-limit stages. Position and status are also readable over the standard addr/cs/rd bus.

---
 rtl/quadrature_input_conditioner.sv | 158 +++++++++++++++
 tb/tb_quadrature_input_conditioner.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_input_conditioner.sv
// Encoder front end: two-flop synchronisers, per-channel stability filters, 4x quadrature decode,
// signed position count, sticky illegal-transition tracking and a small read-only register port.
module quadrature_input_conditioner #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned POS_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        A,
  input  logic                        B,
  input  logic                        clear_pos,
  input  logic [15:0]                 addr,
  input  logic                        cs,
  input  logic                        rd,
  output logic [31:0]                 data_out,
  output logic                        A_filt,
  output logic                        B_filt,
  output logic                        step_pulse,
  output logic                        step_dir,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        err_flag
);

  localparam logic [8:0]           FiltLimit = 9'(FILTER_CYCLES);
  localparam logic [POS_WIDTH-1:0] PosOne    = POS_WIDTH'(1);

  // Channel pairs are packed as {A, B} everywhere below.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [1:0] prev_q;
  logic [7:0] cnt_q   [2];
  logic [7:0] cnt_d   [2];
  logic [8:0] cnt_inc [2];

  logic                        step_pulse_q, step_pulse_d;
  logic                        step_dir_q, step_dir_d;
  logic signed [POS_WIDTH-1:0] position_q, position_d;
  logic                        err_flag_q, err_flag_d;
  logic [7:0]                  err_count_q, err_count_d;
  logic [31:0]                 data_out_q, data_out_d;

  logic        step_fwd, step_rev, illegal;
  logic        rd_en, rd_status;
  logic [31:0] pos_ext, status;

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    unique case (s)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  // A filtered channel only follows its synced input after FILTER_CYCLES unbroken clocks.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = {1'b0, cnt_q[i]} + 9'd1;
      cnt_d[i]   = '0;
      filt_d[i]  = filt_q[i];
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_inc[i] == FiltLimit) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_inc[i][7:0];
        end
      end
    end
  end

  always_comb begin
    step_fwd = (filt_q == fwd_next(prev_q));
    step_rev = (prev_q == fwd_next(filt_q));
    illegal  = ((filt_q ^ prev_q) == 2'b11);

    step_pulse_d = step_fwd | step_rev;
    step_dir_d   = step_dir_q;
    position_d   = position_q;
    if (step_fwd) begin
      step_dir_d = 1'b1;
      position_d = position_q + PosOne;
    end else if (step_rev) begin
      step_dir_d = 1'b0;
      position_d = position_q - PosOne;
    end
    if (clear_pos) begin
      position_d = '0;
    end
  end

  always_comb begin
    rd_en     = cs & rd;
    rd_status = rd_en && (addr == 16'h0001);
    pos_ext   = 32'(position_q);
    status    = {20'b0, filt_q[0], filt_q[1], step_dir_q, err_flag_q, err_count_q};

    // A status read clears the error state, but an illegal transition on the same edge survives.
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (rd_status) begin
      err_flag_d  = illegal;
      err_count_d = illegal ? 8'd1 : 8'd0;
    end else if (illegal) begin
      err_flag_d  = 1'b1;
      err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    end

    data_out_d = data_out_q;
    if (rd_en) begin
      case (addr)
        16'h0000: data_out_d = pos_ext;
        16'h0001: data_out_d = status;
        default:  data_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      filt_q       <= '0;
      prev_q       <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      position_q   <= '0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      data_out_q   <= '0;
    end else begin
      sync1_q      <= {A, B};
      sync2_q      <= sync1_q;
      filt_q       <= filt_d;
      prev_q       <= filt_q;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      step_pulse_q <= step_pulse_d;
      step_dir_q   <= step_dir_d;
      position_q   <= position_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      data_out_q   <= data_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign A_filt     = filt_q[1];
  assign B_filt     = filt_q[0];
  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign position   = position_q;
  assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_quadrature_input_conditioner.sv
// Scoreboard bench: each driven quadrature transition queues its expected step (cycle, dir,
// position); a negedge monitor pops and checks every step_pulse the decoder emits.
module tb_quadrature_input_conditioner;

  localparam int unsigned FILT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        A = 1'b0;
  logic        B = 1'b0;
  logic        clear_pos = 1'b0;
  logic [15:0] addr = '0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] data_out;
  logic        A_filt, B_filt, step_pulse, step_dir, err_flag;
  logic signed [31:0] position;

  quadrature_input_conditioner #(
    .FILTER_CYCLES(FILT),
    .POS_WIDTH    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .clear_pos (clear_pos),
    .addr      (addr),
    .cs        (cs),
    .rd        (rd),
    .data_out  (data_out),
    .A_filt    (A_filt),
    .B_filt    (B_filt),
    .step_pulse(step_pulse),
    .step_dir  (step_dir),
    .position  (position),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    logic        dir;
    logic [31:0] pos;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned cyc = 0;
  logic        m_a = 1'b0;
  logic        m_b = 1'b0;
  logic [31:0] m_pos = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL pulse: unexpected step at cycle %0d (dir %b pos %h), none required",
                 cyc, step_dir, position);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.at || step_dir !== mon_e.dir || position !== mon_e.pos) begin
          n_miss++;
          $display("FAIL pulse: got cyc %0d dir %b pos %h, required cyc %0d dir %b pos %h",
                   cyc, step_dir, position, mon_e.at, mon_e.dir, mon_e.pos);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives a new raw {A,B} at a negedge; legal transitions queue their expected step.
  task automatic drive_step(input logic na, input logic nb, input int dwell, input logic clr);
    logic [1:0] o, n;
    exp_t e;
    @(negedge clk);
    o = {m_a, m_b};
    n = {na, nb};
    if (fwd_of(o) == n) begin
      m_pos = clr ? 32'd0 : m_pos + 32'd1;
      e.at = cyc + 3 + FILT; e.dir = 1'b1; e.pos = m_pos;
      exp_q.push_back(e);
    end else if (fwd_of(n) == o) begin
      m_pos = clr ? 32'd0 : m_pos - 32'd1;
      e.at = cyc + 3 + FILT; e.dir = 1'b0; e.pos = m_pos;
      exp_q.push_back(e);
    end
    A = na; B = nb; m_a = na; m_b = nb;
    if (clr) begin
      repeat (FILT + 2) @(negedge clk);
      clear_pos = 1'b1;
      @(negedge clk);
      clear_pos = 1'b0;
      repeat (dwell - int'(FILT) - 3) @(negedge clk);
    end else begin
      repeat (dwell - 1) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s drain: %0d steps still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = data_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    A = 1'b0; B = 1'b0; clear_pos = 1'b0; cs = 1'b0; rd = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_a = 1'b0; m_b = 1'b0; m_pos = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({data_out, A_filt, B_filt, step_pulse, step_dir, position, err_flag} !== '0) begin
      n_miss++;
      $display("FAIL reset: data %h A %b B %b pulse %b dir %b pos %h err %b, required all 0",
               data_out, A_filt, B_filt, step_pulse, step_dir, position, err_flag);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    logic [1:0] n;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      n = fwd_of({m_a, m_b});
      drive_step(n[1], n[0], 20, 1'b0);
    end
    wait_drain("forward");
    n_vec++;
    if (position !== 32'd16 || step_dir !== 1'b1) begin
      n_miss++;
      $display("FAIL forward: pos %h dir %b, required 00000010 dir 1", position, step_dir);
    end
  endtask

  task automatic test_reverse();
    logic [1:0] n;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n = rev_of({m_a, m_b});
      drive_step(n[1], n[0], 12, 1'b0);
    end
    wait_drain("reverse");
    n_vec++;
    if (position !== 32'hFFFF_FFFD || step_dir !== 1'b0) begin
      n_miss++;
      $display("FAIL reverse: pos %h dir %b, required fffffffd dir 0", position, step_dir);
    end
  endtask

  task automatic test_glitch();
    logic bad = 1'b0;
    do_reset();
    @(negedge clk);
    A = 1'b1;
    repeat (FILT - 1) @(negedge clk);
    A = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (A_filt !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad || position !== 32'd0) begin
      n_miss++;
      $display("FAIL glitch: A_filt rose %b pos %h, required no rise pos 0", bad, position);
    end
    drive_step(1'b1, 1'b0, 12, 1'b0);
    wait_drain("min_pulse");
    n_vec++;
    if (A_filt !== 1'b1 || position !== 32'd1) begin
      n_miss++;
      $display("FAIL min_pulse: A_filt %b pos %h, required 1 and 00000001", A_filt, position);
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  n;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      n = ~{m_a, m_b};
      drive_step(n[1], n[0], 8, 1'b0);
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (position !== 32'd0 || err_flag !== 1'b1) begin
      n_miss++;
      $display("FAIL illegal: pos %h err %b, required 0 and 1", position, err_flag);
    end
    read_reg(16'h0001, d);
    n_vec++;
    if (d !== 32'h0000_01FF) begin
      n_miss++;
      $display("FAIL status_sat: got %h, required 000001ff", d);
    end
    read_reg(16'h0001, d);
    n_vec++;
    if (d !== 32'h0 || err_flag !== 1'b0) begin
      n_miss++;
      $display("FAIL status_clr: got %h err %b, required 0 and 0", d, err_flag);
    end
    // Illegal decode lands on the same edge as a status read.
    @(negedge clk);
    A = 1'b1; B = 1'b1; m_a = 1'b1; m_b = 1'b1;
    repeat (FILT + 2) @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = 16'h0001;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    n_vec++;
    if (data_out !== 32'h0000_0C00) begin
      n_miss++;
      $display("FAIL rd_collide: got %h, required 00000c00", data_out);
    end
    read_reg(16'h0001, d);
    n_vec++;
    if (d !== 32'h0000_0D01) begin
      n_miss++;
      $display("FAIL rd_collide_after: got %h, required 00000d01", d);
    end
  endtask

  task automatic test_clear();
    logic [1:0]  n;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n = fwd_of({m_a, m_b});
      drive_step(n[1], n[0], 10, 1'b0);
    end
    n_vec++;
    if (position !== 32'd9) begin
      n_miss++;
      $display("FAIL pre_clear: pos %h, required 00000009", position);
    end
    n = fwd_of({m_a, m_b});
    drive_step(n[1], n[0], FILT + 3, 1'b1);
    n_vec++;
    if (position !== 32'd0 || step_dir !== 1'b1) begin
      n_miss++;
      $display("FAIL clear: pos %h dir %b, required 0 dir 1", position, step_dir);
    end
    read_reg(16'h0000, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL clear_read: got %h, required 00000000", d);
    end
    n = fwd_of({m_a, m_b});
    drive_step(n[1], n[0], 10, 1'b0);
    wait_drain("clear");
    read_reg(16'h0002, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL unmapped: got %h, required 00000000", d);
    end
    read_reg(16'h0000, d);
    n_vec++;
    if (d !== 32'd1) begin
      n_miss++;
      $display("FAIL pos_read: got %h, required 00000001", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  n;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n = fwd_of({m_a, m_b});
      drive_step(n[1], n[0], 10, 1'b0);
    end
    read_reg(16'h0000, d);
    n_vec++;
    if (d !== 32'd5) begin
      n_miss++;
      $display("FAIL mid_read: got %h, required 00000005", d);
    end
    drive_step(1'b0, 1'b1, 10, 1'b0);
    n_vec++;
    if (err_flag !== 1'b1 || position !== 32'd5) begin
      n_miss++;
      $display("FAIL mid_err: err %b pos %h, required 1 and 00000005", err_flag, position);
    end
    // A legal edge is in the filter when reset hits; it must be discarded.
    @(negedge clk);
    A = 1'b0; B = 1'b0; m_a = 1'b0; m_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pos = '0;
    n_vec++;
    if ({data_out, A_filt, B_filt, step_pulse, step_dir, position, err_flag} !== '0) begin
      n_miss++;
      $display("FAIL mid_reset: data %h A %b B %b pulse %b dir %b pos %h err %b, required all 0",
               data_out, A_filt, B_filt, step_pulse, step_dir, position, err_flag);
    end
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n = fwd_of({m_a, m_b});
      drive_step(n[1], n[0], 10, 1'b0);
    end
    wait_drain("after_reset");
    n_vec++;
    if (position !== 32'd4 || err_flag !== 1'b0) begin
      n_miss++;
      $display("FAIL after_reset: pos %h err %b, required 00000004 and 0", position, err_flag);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_clear();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
